// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the issue path and the multiply/divide unit.
// The master issues operations and reads HI/LO; the slave is the unit itself.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// MULT/MULTU use a shift-add loop over a 64-bit accumulator, DIV/DIVU use
// restoring shift-subtract; signed operations work on magnitudes and apply a
// sign fix-up in a final cycle. MTHI/MTLO write HI/LO directly while idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t state_q, state_d;

    // Accumulator: multiply keeps {partial product, remaining multiplier};
    // divide keeps {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   opA_q;
    logic [4:0]         count_q;
    logic               isDiv_q;
    logic               negRes_q;
    logic               negRem_q;
    logic               divZero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               issueMulDiv;
    logic               isSigned;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] accStep;
    logic [WIDTH-1:0]   hiRes;
    logic [WIDTH-1:0]   loRes;

    assign issueMulDiv = bus.start && !bus.op[2];
    assign isSigned    = !bus.op[0];
    assign magA        = (isSigned && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign magB        = (isSigned && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

    // State register; reset drops any in-flight operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: 32 iteration edges in CALC, then one fix-up edge in FIX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issueMulDiv) state_d = CALC;
            CALC:    if (count_q == 5'd0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Busy is a pure decode of state so the stall path sees it without delay.
    always_comb begin
        bus.busy = (state_q != IDLE);
    end

    // One iteration of either algorithm, selected by the latched operation.
    always_comb begin
        logic [WIDTH:0]   mulSum;
        logic [WIDTH:0]   divShift;
        logic [WIDTH-1:0] divRem;
        mulSum   = '0;
        divShift = '0;
        divRem   = '0;
        accStep  = acc_q;
        if (isDiv_q) begin
            divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            divRem   = divShift[WIDTH-1:0] - opnd_q;
            if (divShift >= {1'b0, opnd_q}) begin
                accStep = {divRem, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                accStep = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            accStep = {mulSum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the magnitude result; a zero divisor bypasses it.
    always_comb begin
        logic [2*WIDTH-1:0] prod;
        prod  = negRes_q ? -acc_q : acc_q;
        hiRes = prod[2*WIDTH-1:WIDTH];
        loRes = prod[WIDTH-1:0];
        if (isDiv_q) begin
            if (divZero_q) begin
                hiRes = opA_q;
                loRes = '1;
            end else begin
                hiRes = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                loRes = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
        end
    end

    // Datapath: operand capture on issue, iterate in CALC, commit in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            opA_q     <= '0;
            count_q   <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MTHI) begin
                            hi_q <= bus.op_a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.op_a;
                        end else if (issueMulDiv) begin
                            isDiv_q   <= bus.op[1];
                            opA_q     <= bus.op_a;
                            count_q   <= 5'd31;
                            negRes_q  <= isSigned && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                            negRem_q  <= isSigned && bus.op_a[WIDTH-1];
                            divZero_q <= (bus.op_b == '0);
                            if (bus.op[1]) begin
                                opnd_q <= magB;
                                acc_q  <= {{WIDTH{1'b0}}, magA};
                            end else begin
                                opnd_q <= magA;
                                acc_q  <= {{WIDTH{1'b0}}, magB};
                            end
                        end
                    end
                end
                CALC: begin
                    acc_q   <= accStep;
                    count_q <= count_q - 5'd1;
                end
                FIX: begin
                    hi_q   <= hiRes;
                    lo_q   <= loRes;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, random operations
// against an arithmetic reference model, busy/move rules and reset behaviour.
module tb_muldiv_unit;

    logic clk;
    logic rst_n;
    int   passCount;
    int   checkCount;

    muldiv_unit_if #(.WIDTH(32)) bus();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eHi;
        logic [31:0] eLo;
    } vec_t;

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          ia;
        int          ib;
        longint      la;
        longint      lb;
        logic [63:0] res;
        ia  = a;
        ib  = b;
        res = '0;
        case (op)
            3'b000: begin
                la  = ia;
                lb  = ib;
                res = la * lb;
            end
            3'b001: res = {32'b0, a} * {32'b0, b};
            3'b010: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
                else res = {32'(ia % ib), 32'(ia / ib)};
            end
            3'b011: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Issue one mul/div starting now and wait (bounded) for its done pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rHi, output logic [31:0] rLo,
                          output int lat, output int pulses, output bit busyOk, output bit holdOk);
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        oldHi       = bus.hi;
        oldLo       = bus.lo;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.op_a    = a;
        bus.op_b    = b;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.op      = 3'($urandom_range(0, 7));
        bus.op_a    = $urandom;
        bus.op_b    = $urandom;
        lat         = 0;
        pulses      = 0;
        busyOk      = 1'b1;
        holdOk      = 1'b1;
        if (bus.done !== 1'b0) pulses++;
        if (bus.busy !== 1'b1) busyOk = 1'b0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                pulses++;
                lat = k;
                if (bus.busy !== 1'b0) busyOk = 1'b0;
            end else begin
                if (bus.busy !== 1'b1) busyOk = 1'b0;
                if (bus.hi !== oldHi || bus.lo !== oldLo) holdOk = 1'b0;
            end
        end
        rHi = bus.hi;
        rLo = bus.lo;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if (bus.hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h want %h", bus.hi, 32'h0); else passCount++;
        checkCount++;
        if (bus.lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h want %h", bus.lo, 32'h0); else passCount++;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passCount++;
        checkCount++;
        if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done); else passCount++;
    endtask

    task automatic test_directed;
        vec_t        vecs[6];
        logic [31:0] rHi;
        logic [31:0] rLo;
        int          lat;
        int          pulses;
        bit          busyOk;
        bit          holdOk;
        vecs[0] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{3'b011, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
        vecs[5] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, rHi, rLo, lat, pulses, busyOk, holdOk);
            checkCount++;
            if (rHi !== vecs[i].eHi) $display("[TB] FAIL directed_hi[%0d]: got %h want %h", i, rHi, vecs[i].eHi); else passCount++;
            checkCount++;
            if (rLo !== vecs[i].eLo) $display("[TB] FAIL directed_lo[%0d]: got %h want %h", i, rLo, vecs[i].eLo); else passCount++;
            checkCount++;
            if (lat !== 33) $display("[TB] FAIL directed_latency[%0d]: got %0d want 33", i, lat); else passCount++;
            checkCount++;
            if (busyOk !== 1'b1) $display("[TB] FAIL directed_busy[%0d]: got %b want 1", i, busyOk); else passCount++;
            checkCount++;
            if (holdOk !== 1'b1) $display("[TB] FAIL directed_hold[%0d]: got %b want 1", i, holdOk); else passCount++;
            @(posedge clk);
            #1;
            checkCount++;
            if (bus.done !== 1'b0 || pulses !== 1)
                $display("[TB] FAIL directed_single_done[%0d]: got pulses=%0d done_after=%b want 1/0", i, pulses, bus.done);
            else passCount++;
        end
    endtask

    // Random operands are biased toward sign/zero boundary values.
    function automatic logic [31:0] pick_operand();
        logic [31:0] specials[6];
        specials[0] = 32'h00000000;
        specials[1] = 32'h00000001;
        specials[2] = 32'hFFFFFFFF;
        specials[3] = 32'h80000000;
        specials[4] = 32'h7FFFFFFF;
        specials[5] = 32'h00010000;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_random_back_to_back;
        logic [31:0] rHi;
        logic [31:0] rLo;
        logic [63:0] exp;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          pulses;
        bit          busyOk;
        bit          holdOk;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 3));
            a   = pick_operand();
            b   = pick_operand();
            exp = model(op, a, b);
            run_op(op, a, b, rHi, rLo, lat, pulses, busyOk, holdOk);
            checkCount++;
            if ({rHi, rLo} !== exp || lat !== 33 || pulses !== 1 || !busyOk)
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h%h lat=%0d pulses=%0d busyOk=%b want %h lat=33 pulses=1",
                         i, op, a, b, rHi, rLo, lat, pulses, busyOk, exp);
            else passCount++;
        end
        @(posedge clk);
        #1;
        checkCount++;
        if (bus.done !== 1'b0) $display("[TB] FAIL random_done_drop: got %b want 0", bus.done); else passCount++;
    endtask

    task automatic test_busy_moves;
        int  lat;
        bit  seenEarlyHi;
        lat         = 0;
        seenEarlyHi = 1'b0;
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.op_a  = 32'd6;
        bus.op_b  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            if (k == 10) begin
                bus.start = 1'b1;
                bus.op    = 3'b100;
                bus.op_a  = 32'h1234;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) lat = k;
            else if (bus.hi === 32'h1234) seenEarlyHi = 1'b1;
        end
        checkCount++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'd42 || lat !== 33 || seenEarlyHi)
            $display("[TB] FAIL busy_ignore_mthi: got hi=%h lo=%h lat=%0d early=%b want hi=0 lo=2a lat=33 early=0",
                     bus.hi, bus.lo, lat, seenEarlyHi);
        else passCount++;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.op_a  = 32'h1234;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkCount++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'd42) $display("[TB] FAIL idle_mthi: got hi=%h lo=%h want 1234/2a", bus.hi, bus.lo); else passCount++;
        checkCount++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("[TB] FAIL idle_mthi_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done); else passCount++;
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.op_a  = 32'hABCD0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkCount++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'hABCD0001) $display("[TB] FAIL idle_mtlo: got hi=%h lo=%h want 1234/abcd0001", bus.hi, bus.lo); else passCount++;
        bus.start = 1'b1;
        bus.op    = 3'($urandom_range(6, 7));
        bus.op_a  = 32'h5555AAAA;
        bus.op_b  = 32'h3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'hABCD0001 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("[TB] FAIL noop_ignored: got hi=%h lo=%h busy=%b done=%b want 1234/abcd0001/0/0", bus.hi, bus.lo, bus.busy, bus.done);
        else passCount++;
    endtask

    task automatic test_reset_midop;
        int doneSeen;
        doneSeen  = 0;
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("[TB] FAIL midop_reset_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done); else passCount++;
        checkCount++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) $display("[TB] FAIL midop_reset_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo); else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen++;
        end
        checkCount++;
        if (doneSeen !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'h0)
            $display("[TB] FAIL midop_no_done: got activity=%0d hi=%h lo=%h want 0/0/0", doneSeen, bus.hi, bus.lo);
        else passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_busy_moves();
        test_reset_midop();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
